// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: operation modes and FSM states.
package shifter_pkg;

    // Operation select carried on in_mode and held in the mode register.
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-stage shifter. It moves data by 0..STEP positions in one
// of four modes. Only distances up to STEP are built, so the stage stays small
// no matter how wide the operand is.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] shifted
);

    // One candidate result per legal distance 0..STEP.
    logic [WIDTH-1:0] cand [STEP+1];

    generate
        for (genvar gi = 0; gi <= STEP; gi++) begin : g_cand
            // Rotation by 0 works because a left shift by WIDTH yields all zeros.
            assign cand[gi] = (mode == SH_SLL) ? (data << gi) :
                              (mode == SH_SRL) ? (data >> gi) :
                              (mode == SH_SRA) ? $unsigned($signed(data) >>> gi) :
                                                 ((data >> gi) | (data << (WIDTH - gi)));
        end
    endgenerate

    // Pick the candidate that matches the requested distance.
    always_comb begin
        shifted = data;
        for (int k = 0; k <= STEP; k++) begin
            if (amount == AMT_W'(k)) begin
                shifted = cand[k];
            end
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROR). It moves at most STEP bit positions per
// clock and uses valid/ready handshakes on both the operand and result sides.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    // STEP always fits in SHAMT_W bits because it is at most WIDTH-1.
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   data_reg;
    logic [SHAMT_W-1:0] remaining_reg;
    logic [1:0]         mode_reg;
    logic [SHAMT_W-1:0] step_amt;
    logic [WIDTH-1:0]   step_data;

    // This cycle's distance: whatever is left, capped at STEP.
    assign step_amt = (remaining_reg > STEP_AMT) ? STEP_AMT : remaining_reg;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data    (data_reg),
        .amount  (step_amt),
        .mode    (mode_reg),
        .shifted (step_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A zero amount skips SHIFT entirely.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (remaining_reg == step_amt) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, step while shifting, and hold in DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg      <= '0;
            remaining_reg <= '0;
            mode_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_reg      <= in_data;
                        remaining_reg <= in_shamt;
                        mode_reg      <= in_mode;
                    end
                end
                ST_SHIFT: begin
                    data_reg      <= step_data;
                    remaining_reg <= remaining_reg - step_amt;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg == ST_SHIFT) || (state_reg == ST_DONE);
    assign out_data  = data_reg;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (WIDTH=32, STEP=4): directed cases followed
// by a randomized regression checked against a bit-index reference model.
module tb_seq_shifter;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    seq_shifter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each result bit is taken from the source bit it lands on.
    function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] x, input int s);
        logic [31:0] r;
        int src;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            case (m)
                2'b00: begin src = i - s; r[i] = (src >= 0) ? x[src] : 1'b0; end
                2'b01: begin src = i + s; r[i] = (src < 32) ? x[src] : 1'b0; end
                2'b10: begin src = i + s; r[i] = (src < 32) ? x[src] : x[31]; end
                default: begin src = (i + s) % 32; r[i] = x[src]; end
            endcase
        end
        return r;
    endfunction

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One full transaction, entered and left at a negedge with the DUT idle.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] x,
                          input int s, input int stall);
        int lat;
        logic [31:0] exp_data;
        logic [31:0] held;
        exp_data = ref_shift(m, x, s);
        check_bit({tag, "_in_ready_pre"}, in_ready, 1'b1);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = x;
        in_shamt = 5'(s);
        @(posedge clk);                 // accept edge closes cycle A
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            check_bit({tag, "_busy_shift"}, busy, 1'b1);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_shamt  = 5'($urandom_range(0, 31));
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_word({tag, "_latency"}, 32'(lat), 32'(1 + (s + STEP - 1) / STEP));
        check_word({tag, "_data"}, out_data, exp_data);
        check_bit({tag, "_busy_done"}, busy, 1'b1);
        held = out_data;
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_shamt  = 5'($urandom_range(0, 31));
            in_mode   = 2'($urandom_range(0, 3));
            @(posedge clk);
            @(negedge clk);
            check_bit({tag, "_stall_valid"}, out_valid, 1'b1);
            check_bit({tag, "_stall_in_ready"}, in_ready, 1'b0);
            check_word({tag, "_stall_data"}, out_data, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);                 // result handshake
        @(negedge clk);
        out_ready = 1'b0;
        check_bit({tag, "_in_ready_post"}, in_ready, 1'b1);
        check_bit({tag, "_out_valid_post"}, out_valid, 1'b0);
        check_bit({tag, "_busy_post"}, busy, 1'b0);
        $display("op %s mode=%0d data=0x%08h shamt=%0d stall=%0d -> 0x%08h lat=%0d",
                 tag, m, x, s, stall, held, lat);
    endtask

    initial begin
        logic [1:0]  r_mode;
        logic [31:0] r_data;
        int          r_shamt;
        int          r_stall;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_word("reset_out_data", out_data, 32'h0);

        // Directed cases
        run_op("sll_1_by_5",    2'b00, 32'h0000_0001, 5,  0);
        run_op("sra_msb_by_31", 2'b10, 32'h8000_0000, 31, 0);
        run_op("srl_msb_by_31", 2'b01, 32'h8000_0000, 31, 0);
        run_op("ror_ff_by_4",   2'b11, 32'h0000_00FF, 4,  0);
        run_op("srl_ones_by_0", 2'b01, 32'hFFFF_FFFF, 0,  0);
        run_op("backpressure",  2'b00, 32'h1234_5678, 7,  3);
        check_word("const_sra", ref_shift(2'b10, 32'h8000_0000, 31), 32'hFFFF_FFFF);

        // Reset in the middle of an operation
        in_valid = 1'b1;
        in_mode  = 2'b00;
        in_data  = 32'h0000_0001;
        in_shamt = 5'd20;
        @(posedge clk);                 // accept, cycle A
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);                 // cycle A+3
        check_bit("midop_busy", busy, 1'b1);
        check_bit("midop_no_valid", out_valid, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_bit("midop_rst_in_ready", in_ready, 1'b1);
        check_bit("midop_rst_out_valid", out_valid, 1'b0);
        check_word("midop_rst_out_data", out_data, 32'h0);
        $display("op midop_reset sll 0x00000001 by 20 aborted at A+3");
        run_op("after_reset_srl", 2'b01, 32'h0000_0100, 8, 0);

        // Random regression
        for (int n = 0; n < 1000; n++) begin
            r_mode  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       r_data = 32'h8000_0000 | $urandom;
                1:       r_data = 32'h0000_0001 << $urandom_range(0, 31);
                default: r_data = $urandom;
            endcase
            r_shamt = $urandom_range(0, 31);
            r_stall = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            run_op($sformatf("rand%0d", n), r_mode, r_data, r_shamt, r_stall);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
